// File: rtl/cla_serial_addsub_pkg.sv
// Shared types and constants for the nibble-serial CLA adder/subtractor.
`ifndef CLA_SERIAL_ADDSUB_PKG_SV
`define CLA_SERIAL_ADDSUB_PKG_SV

`define CSA_STEPS(w) ((w) / 4)

package cla_serial_addsub_pkg;

    localparam int NIBBLE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`endif

// File: rtl/cla_serial_addsub_cla4.sv
// Combinational 4-bit carry-lookahead slice with group propagate/generate.
module cla_serial_addsub_cla4
    import cla_serial_addsub_pkg::*;
(
    input  logic [NIBBLE-1:0] a,
    input  logic [NIBBLE-1:0] b,
    input  logic              c_in,
    output logic [NIBBLE-1:0] sum,
    output logic              c_out,
    output logic              P,
    output logic              G
);

    logic [NIBBLE-1:0] p;
    logic [NIBBLE-1:0] g;
    logic [NIBBLE:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0] = c_in;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);

    assign P = &p;
    assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);

    assign c[4]  = G | (P & c[0]);
    assign c_out = c[4];
    assign sum   = p ^ c[NIBBLE-1:0];

endmodule

// File: rtl/cla_serial_addsub.sv
// WIDTH-bit adder/subtractor that pushes one nibble per cycle through a CLA slice.
module cla_serial_addsub
    import cla_serial_addsub_pkg::*;
#(
    parameter int WIDTH = 16
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             P,
    output logic             G
);

    localparam int STEPS = `CSA_STEPS(WIDTH);
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [CW+1:0]  base;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic           carry;
    logic           p_acc;
    logic           g_acc;

    logic [NIBBLE-1:0] s_sum;
    logic              s_cout;
    logic              s_p;
    logic              s_g;
    logic              p_nxt;
    logic              g_nxt;
    logic              last;

    assign base = {cnt, 2'b00};

    cla_serial_addsub_cla4 u_slice (
        .a     (a_r[base +: NIBBLE]),
        .b     (b_r[base +: NIBBLE]),
        .c_in  (carry),
        .sum   (s_sum),
        .c_out (s_cout),
        .P     (s_p),
        .G     (s_g)
    );

    assign p_nxt = p_acc & s_p;
    assign g_nxt = s_g | (s_p & g_acc);
    assign last  = (cnt == CW'(STEPS - 1));

    // Gate with rst so the handshake is closed while reset is held.
    assign in_ready = rst & (state == IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            a_r       <= '0;
            b_r       <= '0;
            carry     <= 1'b0;
            p_acc     <= 1'b0;
            g_acc     <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
            P         <= 1'b0;
            G         <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= sub ? ~b : b;
                        carry <= sub | c_in;
                        p_acc <= 1'b1;
                        g_acc <= 1'b0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[base +: NIBBLE] <= s_sum;
                    carry <= s_cout;
                    p_acc <= p_nxt;
                    g_acc <= g_nxt;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        cnt       <= '0;
                        c_out     <= s_cout;
                        // Carry into the MSB recovered from the MSB sum bit.
                        ovf       <= a_r[WIDTH-1] ^ b_r[WIDTH-1]
                                   ^ s_sum[NIBBLE-1] ^ s_cout;
                        P         <= p_nxt;
                        G         <= g_nxt;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_serial_addsub.sv
// Directed and random checks of cla_serial_addsub against an arithmetic model.
module tb_cla_serial_addsub;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         c_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
    logic         P;
    logic         G;

    int checks = 0;
    int fails = 0;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        logic         p;
        logic         g;
    } res_t;

    always #5 clk = ~clk;

    cla_serial_addsub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf),
        .P         (P),
        .G         (G)
    );

    function automatic res_t model(input logic [W-1:0] x,
                                   input logic [W-1:0] y,
                                   input logic sb, input logic ci);
        res_t r;
        logic [W-1:0] yy;
        logic [W:0]   full;
        logic [W:0]   nocarry;
        yy      = sb ? ~y : y;
        full    = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (sb | ci)};
        nocarry = {1'b0, x} + {1'b0, yy};
        r.s  = full[W-1:0];
        r.co = full[W];
        r.ov = (x[W-1] == yy[W-1]) && (r.s[W-1] != x[W-1]);
        r.p  = ((x ^ yy) == {W{1'b1}});
        r.g  = nocarry[W];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_res(input string tag, input res_t e);
        check({tag, ".sum"}, 32'(sum), 32'(e.s));
        check({tag, ".c_out"}, 32'(c_out), 32'(e.co));
        check({tag, ".ovf"}, 32'(ovf), 32'(e.ov));
        check({tag, ".P"}, 32'(P), 32'(e.p));
        check({tag, ".G"}, 32'(G), 32'(e.g));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".in_ready"}, 32'(in_ready), 0);
        check({tag, ".out_valid"}, 32'(out_valid), 0);
        check({tag, ".sum"}, 32'(sum), 0);
        check({tag, ".flags"}, {28'd0, c_out, ovf, P, G}, 0);
    endtask

    // Issues one operation, waits for the result, checks it, then retires it.
    task automatic run_op(input string tag, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic sb,
                          input logic ci);
        res_t e;
        int lat;
        e = model(x, y, sb, ci);
        @(negedge clk);
        a = x; b = y; sub = sb; c_in = ci; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".lat"}, 32'(lat), 4);
        check_res(tag, e);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".release"}, 32'(out_valid), 0);
    endtask

    initial begin
        res_t e;
        res_t q[$];
        int t;
        int got;
        int last_t;
        int idx;
        logic spur;

        // Reset state
        repeat (2) @(negedge clk);
        check_zero("rst0");
        rst = 1'b1;
        @(negedge clk);
        check("rst0.ready_after", 32'(in_ready), 1);

        // Reset in the middle of RUN aborts the operation
        a = 16'h1234; b = 16'h4321; sub = 1'b0; c_in = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_zero("rst_run.now");
        repeat (2) @(negedge clk);
        check_zero("rst_run.held");
        rst = 1'b1;
        @(negedge clk);
        check("rst_run.ready", 32'(in_ready), 1);
        spur = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) spur = 1'b1;
        end
        check("rst_run.no_result", 32'(spur), 0);

        // Directed corner cases
        run_op("add_5555", 16'h1234, 16'h4321, 1'b0, 1'b0);
        check("add_5555.const", 32'(sum), 32'h5555);
        run_op("add_wrap", 16'hFFFF, 16'h0000, 1'b0, 1'b1);
        check("add_wrap.P", 32'(P), 1);
        run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b0);
        check("sub_ovf.const", {15'd0, sum, c_out, ovf}, {15'd0, 16'h7FFF, 2'b11});
        run_op("sub_zero", 16'h0005, 16'h0005, 1'b1, 1'b1);
        check("sub_zero.const", {15'd0, sum, c_out, ovf}, {15'd0, 16'h0000, 2'b10});
        run_op("add_gen", 16'h8000, 16'h8000, 1'b0, 1'b0);

        // Result held under back-pressure while in_valid pulses
        e = model(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; sub = 1'b0; c_in = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("hold.lat", 32'(t), 4);
        for (int i = 0; i < 5; i++) begin
            a = W'($urandom); b = W'($urandom); in_valid = ~i[0];
            @(negedge clk);
            check("hold.valid", 32'(out_valid), 1);
            check("hold.sum", 32'(sum), 32'(e.s));
            check("hold.ready", 32'(in_ready), 0);
        end
        check_res("hold", e);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        spur = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid || !in_ready) spur = 1'b1;
        end
        check("hold.no_capture", 32'(spur), 0);

        // Random operations
        for (int i = 0; i < 16; i++) begin
            run_op("rand", W'($urandom), W'($urandom),
                   1'($urandom), 1'($urandom));
        end

        // Back-to-back throughput
        t = 0; got = 0; last_t = -1; idx = 0;
        out_ready = 1'b1;
        while (got < 3 && t < 100) begin
            @(negedge clk);
            t++;
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("tp.spurious", 1, 0);
                end else begin
                    e = q.pop_front();
                    check_res("tp", e);
                end
                if (last_t >= 0) check("tp.gap", 32'(t - last_t), 6);
                last_t = t;
                got++;
            end
            if (in_ready) begin
                if (idx < 3) begin
                    a = W'($urandom); b = W'($urandom);
                    sub = 1'($urandom); c_in = 1'($urandom);
                    q.push_back(model(a, b, sub, c_in));
                    in_valid = 1'b1;
                    idx++;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("tp.count", 32'(got), 3);
        in_valid = 1'b0;
        out_ready = 1'b0;

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
